// File: rtl/ropes_scheduler.sv
// rtl/ropes_scheduler.sv - round-robin launcher and per-frame extend/hold/retract sequencer for four ropes
// Optional feature macro: ROPE_GRAB_FREEZE_EN (grab[i] pauses rope i while in HOLD or RETRACT).
module ropes_scheduler #(
  parameter int LEN_W       = 8,
  parameter int MAX_LEN     = 200,
  parameter int STEP        = 2,
  parameter int HOLD_FRAMES = 60,
  parameter int GAP_FRAMES  = 30,
  parameter int MAX_ACTIVE  = 2
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             enable,
  input  logic [3:0]       grab,
  output logic [3:0]       ropeVisible,
  output logic [LEN_W-1:0] ropeLen0,
  output logic [LEN_W-1:0] ropeLen1,
  output logic [LEN_W-1:0] ropeLen2,
  output logic [LEN_W-1:0] ropeLen3,
  output logic [1:0]       nextRope,
  output logic             busy
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int GW = $clog2(GAP_FRAMES + 1);

  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_EXTEND  = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_RETRACT = 2'd3;

  localparam logic [LEN_W:0]  STEP_X    = (LEN_W+1)'(STEP);
  localparam logic [LEN_W:0]  MAX_X     = (LEN_W+1)'(MAX_LEN);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [GW-1:0]   GAP_FULL  = GW'(GAP_FRAMES);
  localparam logic [2:0]      ACT_MAX   = 3'(MAX_ACTIVE);

`ifdef ROPE_GRAB_FREEZE_EN
  localparam bit GRAB_FREEZE = 1'b1;
`else
  localparam bit GRAB_FREEZE = 1'b0;
`endif

  logic [1:0]       rope_st  [4];
  logic [LEN_W-1:0] rope_len [4];
  logic [HW-1:0]    hold_cnt [4];
  logic [1:0]       st_nxt   [4];
  logic [LEN_W-1:0] len_nxt  [4];
  logic [HW-1:0]    hold_nxt [4];
  logic [LEN_W:0]   ext_sum  [4];

  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [1:0]    next_rope, next_nxt;
  logic [2:0]    active_cnt;
  logic [3:0]    frz;
  logic          armed, tick, launch;

  // armed masks the first edge after reset release so a coincident frame pulse is dropped
  assign tick = startOfFrame & enable & armed;
  assign frz  = GRAB_FREEZE ? grab : 4'b0000;

  always_comb begin
    ropeVisible = 4'b0000;
    active_cnt  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      ropeVisible[i] = (rope_st[i] != ST_OFF);
      active_cnt     = active_cnt + {2'b00, ropeVisible[i]};
    end
  end

  assign busy     = (active_cnt == ACT_MAX);
  assign nextRope = next_rope;
  assign ropeLen0 = rope_len[0];
  assign ropeLen1 = rope_len[1];
  assign ropeLen2 = rope_len[2];
  assign ropeLen3 = rope_len[3];

  // Launch arbitration works only on pre-tick state, so a rope retiring now cannot be relaunched.
  always_comb begin
    gap_nxt  = gap_cnt;
    next_nxt = next_rope;
    launch   = 1'b0;
    if (gap_cnt != GAP_FULL) begin
      gap_nxt = gap_cnt + 1'b1;
    end else if ((rope_st[next_rope] == ST_OFF) && (active_cnt < ACT_MAX)) begin
      launch   = 1'b1;
      gap_nxt  = '0;
      next_nxt = next_rope + 2'd1;
    end else if (rope_st[next_rope] != ST_OFF) begin
      next_nxt = next_rope + 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_nxt[i]   = rope_st[i];
      len_nxt[i]  = rope_len[i];
      hold_nxt[i] = hold_cnt[i];
      ext_sum[i]  = {1'b0, rope_len[i]} + STEP_X;
      case (rope_st[i])
        ST_OFF: begin
          if (launch && (next_rope == 2'(i))) begin
            st_nxt[i]  = ST_EXTEND;
            len_nxt[i] = '0;
          end
        end
        ST_EXTEND: begin
          if (ext_sum[i] >= MAX_X) begin
            len_nxt[i]  = MAX_X[LEN_W-1:0];
            st_nxt[i]   = ST_HOLD;
            hold_nxt[i] = '0;
          end else begin
            len_nxt[i] = ext_sum[i][LEN_W-1:0];
          end
        end
        ST_HOLD: begin
          if (!frz[i]) begin
            if (hold_cnt[i] == HOLD_LAST) st_nxt[i] = ST_RETRACT;
            else                          hold_nxt[i] = hold_cnt[i] + 1'b1;
          end
        end
        default: begin
          if (!frz[i]) begin
            if ({1'b0, rope_len[i]} <= STEP_X) begin
              len_nxt[i] = '0;
              st_nxt[i]  = ST_OFF;
            end else begin
              len_nxt[i] = rope_len[i] - STEP_X[LEN_W-1:0];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      armed     <= 1'b0;
      gap_cnt   <= '0;
      next_rope <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        rope_st[i]  <= ST_OFF;
        rope_len[i] <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      armed <= 1'b1;
      if (tick) begin
        gap_cnt   <= gap_nxt;
        next_rope <= next_nxt;
        for (int i = 0; i < 4; i++) begin
          rope_st[i]  <= st_nxt[i];
          rope_len[i] <= len_nxt[i];
          hold_cnt[i] <= hold_nxt[i];
        end
      end
    end
  end

endmodule

// File: doc/ropes_scheduler.md
# ropes_scheduler

Sequences the four climbable ropes (vines) over game time. Each rope is launched in round-robin order, extends, holds, retracts and turns off on a per-frame tick. At most `MAX_ACTIVE` ropes may be alive at once. Per-rope visibility and length outputs feed the four rope drawing units, whose draw requests are then merged by the rope priority mux.

## Interface
- `LEN_W`, 8: rope length width, in pixels.
- `MAX_LEN`, 200: fully extended length; must be ≥ 1 and < 2^LEN_W.
- `STEP`, 2: length change per frame tick; must be ≥ 1.
- `HOLD_FRAMES`, 60: ticks spent in HOLD; must be ≥ 1.
- `GAP_FRAMES`, 30: ticks between launches; must be ≥ 1.
- `MAX_ACTIVE`, 2: maximum ropes not OFF; must be 1..4.
- `clk` in 1: system clock (pixel clock domain).
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per video frame.
- `enable` in 1: game running; 0 freezes all state.
- `grab` in 4: bit i = player holding rope i (used only with `ROPE_GRAB_FREEZE_EN`).
- `ropeVisible` out 4: bit i = 1 when rope i is not OFF.
- `ropeLen0`..`ropeLen3` out LEN_W each: current length of each rope.
- `nextRope` out 2: index of the next rope to be launched.
- `busy` out 1: 1 when the active count equals `MAX_ACTIVE`.

## Operation
- **Tick** = cycle with `startOfFrame=1` and `enable=1`. All state changes occur only on ticks. Non-tick cycles hold all state.
- **Per-rope FSM**: OFF → EXTEND → HOLD → RETRACT → OFF.
- **Active count**: the number of ropes not OFF. It is evaluated from pre-tick state, so a rope retiring on a tick does not free a slot until the next tick.
- **Gap counter**:
  - `gapCnt` increments each tick, saturating at `GAP_FRAMES`.
  - On a tick with `gapCnt==GAP_FRAMES`, exactly one of these applies:
    - Rope `nextRope` is OFF and active count < `MAX_ACTIVE`: launch it (state EXTEND, len 0), `gapCnt`←0, `nextRope`←`nextRope`+1 mod 4.
    - Rope `nextRope` is not OFF: skip it (`nextRope`+1 mod 4), `gapCnt` stays at `GAP_FRAMES`, retry next tick.
    - Active count = `MAX_ACTIVE`: wait; `nextRope` and `gapCnt` are unchanged.
- **EXTEND**:
  - If len+STEP ≥ `MAX_LEN`: len←`MAX_LEN`, state HOLD, holdCnt←0.
  - Otherwise len←len+STEP.
  - The sum is computed at LEN_W+1 bits, so there is no wrap.
- **HOLD**: if holdCnt==`HOLD_FRAMES`−1, state RETRACT with len unchanged; otherwise holdCnt+1. holdCnt width is clog2(HOLD_FRAMES+1).
- **RETRACT**: if len ≤ STEP, len←0 and state OFF; otherwise len←len−STEP. There is no underflow.
- **Launch on the retiring tick**: a rope launched on the tick is not otherwise updated that tick. A rope retiring to OFF on a tick cannot be relaunched on that same tick.
- **`enable` low**: everything frozen, including `gapCnt`. Ticks are ignored.
- **Reset** (asynchronous, mid-operation included): all ropes OFF, all len 0, `gapCnt`=0, `nextRope`=0. Therefore `ropeVisible`=0, all `ropeLenN`=0 and `busy`=0.

## Timing
- All outputs are registered. They reflect the tick's update on the cycle after the tick.
- `ropeVisible[i]` and `busy` are decoded from registered state, with no combinational path from inputs.
- First launch occurs on tick number `GAP_FRAMES`+1 after reset release.
- Rope lifetime from launch, with no stalls: ceil(MAX_LEN/STEP) ticks in EXTEND, `HOLD_FRAMES` in HOLD, ceil(MAX_LEN/STEP) in RETRACT.
- A `startOfFrame` pulse arriving in the same cycle as reset deassertion is ignored.

## Configuration
- **`ROPE_GRAB_FREEZE_EN` defined**:
  - In HOLD, `grab[i]=1` on a tick freezes holdCnt.
  - In RETRACT, `grab[i]=1` on a tick freezes len.
  - EXTEND and OFF ignore `grab`.
- **`ROPE_GRAB_FREEZE_EN` undefined**: `grab` is unused and ropes follow their schedule regardless of the player.

## Test plan
Test parameters: GAP_FRAMES=2, STEP=4, MAX_LEN=16, HOLD_FRAMES=3, MAX_ACTIVE=2.
- **Launch and extend**: reset, then ticks 1..7 → rope0 launches on tick 3 with len 0, then len 4,8,12,16. HOLD entered at tick 7. `nextRope`=1 after tick 3. Rope1 launches on tick 6.
- **Hold and retract**: rope0 in HOLD from tick 7 → RETRACT entered on tick 10 with len 16. Len 12,8,4 on ticks 11..13, then 0 and OFF on tick 14.
- **Active cap**: rope0 and rope1 alive on tick 9 → `busy`=1. Rope2 is not launched and `nextRope` stays 2 until a rope reaches OFF. Rope2 launches on the first tick after that.
- **Freeze and spurious pulses**: `enable`=0 with 10 `startOfFrame` pulses → no output or counter change. `startOfFrame` pulses 2 cycles wide → count as 2 ticks.
- **Reset mid-operation**: assert `resetN`=0 while two ropes are alive → all outputs 0 asynchronously. After release, the first launch is again on tick 3.
- **Grab freeze**: with `ROPE_GRAB_FREEZE_EN`, hold `grab[0]`=1 through HOLD → rope0 remains HOLD with len 16 indefinitely. Releasing it → RETRACT after the remaining hold ticks. Without the macro → RETRACT on tick 10 regardless of `grab`.
